// File: rtl/pll_rst_seq_pkg.sv
// Shared definitions for the PLL power-up / reset sequencer: FSM state encodings
// and the width helper for the shared cycle counter.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PD        = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    // One extra bit above the largest limit so the counter can saturate instead of wrapping
    function automatic int cnt_width(input int pd_cycles, input int lock_timeout, input int stable_cycles);
        int max_v;
        max_v = pd_cycles;
        max_v = (lock_timeout > max_v) ? lock_timeout : max_v;
        max_v = (stable_cycles > max_v) ? stable_cycles : max_v;
        return $clog2(max_v) + 32'sd1;
    endfunction

endpackage

// File: rtl/pll_rst_seq_sync2.sv
// Two-flop synchronizer for the asynchronous PLL lock input; flops clear to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL power-up and staged domain reset sequencer. The WAIT_LOCK timeout and the
// sticky fault flag exist only when PLL_RST_SEQ_TIMEOUT_EN is defined.
module pll_rst_seq
    import pll_seq_pkg::*;
#(
    parameter int PD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int N_DOMAINS     = 3,
    parameter int STAGE_GAP     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_lock,
    input  logic                 sw_reset_req,
    output logic                 pll_pd,
    output logic [N_DOMAINS-1:0] rst_out,
    output logic                 ready,
    output logic                 fault,
    output logic [7:0]           lock_lost_cnt,
    output logic [2:0]           state
);

    localparam int CNT_W = cnt_width(PD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int STG_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    localparam logic [CNT_W-1:0]     CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]     CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]     CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]     PD_LAST     = CNT_W'(PD_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0]     STABLE_LAST = CNT_W'(STABLE_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0]     GAP_LAST    = CNT_W'(STAGE_GAP - 32'sd1);
`ifdef PLL_RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0]     TO_LAST     = CNT_W'(LOCK_TIMEOUT - 32'sd1);
`endif
    localparam logic [STG_W-1:0]     STG_ZERO    = {STG_W{1'b0}};
    localparam logic [STG_W-1:0]     STG_ONE     = {{(STG_W-1){1'b0}}, 1'b1};
    localparam logic [STG_W-1:0]     LAST_STAGE  = STG_W'(N_DOMAINS - 32'sd1);
    localparam logic [N_DOMAINS-1:0] RST_ALL     = {N_DOMAINS{1'b1}};

    logic                 lock_s;

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s, cnt_inc_s;
    logic [STG_W-1:0]     stage_r, stage_s;
    logic                 pll_pd_r, pll_pd_s;
    logic [N_DOMAINS-1:0] rst_out_r, rst_out_s;
    logic                 ready_r, ready_s;
    logic [7:0]           lost_r, lost_s;
    logic                 lost_event_s;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
    logic                 fault_r, fault_s;
`endif

    sync2 u_sync_lock (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // Next-state and next-output decode; software request outranks lock loss, which outranks normal flow
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        stage_s   = stage_r;
        pll_pd_s  = pll_pd_r;
        rst_out_s = rst_out_r;
        ready_s   = ready_r;
`ifdef PLL_RST_SEQ_TIMEOUT_EN
        fault_s   = fault_r;
`endif
        cnt_inc_s    = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
        lost_event_s = ((state_r == ST_RELEASE) || (state_r == ST_RUN)) && !lock_s;

        if (lost_event_s && (lost_r != 8'hFF)) begin
            lost_s = lost_r + 8'd1;
        end else begin
            lost_s = lost_r;
        end

        if (sw_reset_req) begin
            state_s   = ST_PD;
            cnt_s     = CNT_ZERO;
            stage_s   = STG_ZERO;
            pll_pd_s  = 1'b1;
            rst_out_s = RST_ALL;
            ready_s   = 1'b0;
        end else if (lost_event_s) begin
            // Lock dropped after release began: re-lock without powering the PLL down
            state_s   = ST_WAIT_LOCK;
            cnt_s     = CNT_ZERO;
            stage_s   = STG_ZERO;
            pll_pd_s  = 1'b0;
            rst_out_s = RST_ALL;
            ready_s   = 1'b0;
        end else begin
            case (state_r)
                ST_PD: begin
                    rst_out_s = RST_ALL;
                    ready_s   = 1'b0;
                    if (cnt_r >= PD_LAST) begin
                        state_s  = ST_WAIT_LOCK;
                        cnt_s    = CNT_ZERO;
                        pll_pd_s = 1'b0;
                    end else begin
                        cnt_s    = cnt_inc_s;
                        pll_pd_s = 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    pll_pd_s = 1'b0;
                    if (lock_s) begin
                        state_s = ST_STABLE;
                        cnt_s   = CNT_ZERO;
                    end else begin
`ifdef PLL_RST_SEQ_TIMEOUT_EN
                        if (cnt_r >= TO_LAST) begin
                            state_s  = ST_PD;
                            cnt_s    = CNT_ZERO;
                            pll_pd_s = 1'b1;
                            fault_s  = 1'b1;
                        end else begin
                            cnt_s = cnt_inc_s;
                        end
`else
                        cnt_s = cnt_inc_s;
`endif
                    end
                end
                ST_STABLE: begin
                    pll_pd_s = 1'b0;
                    if (!lock_s) begin
                        state_s = ST_WAIT_LOCK;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_r >= STABLE_LAST) begin
                        // Bit 0 is released on the same edge that enters RELEASE
                        cnt_s     = CNT_ZERO;
                        stage_s   = STG_ZERO;
                        rst_out_s = rst_out_r << 1'b1;
                        if (STG_ZERO == LAST_STAGE) begin
                            state_s = ST_RUN;
                            ready_s = 1'b1;
                        end else begin
                            state_s = ST_RELEASE;
                        end
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_RELEASE: begin
                    pll_pd_s = 1'b0;
                    if (cnt_r >= GAP_LAST) begin
                        cnt_s     = CNT_ZERO;
                        stage_s   = stage_r + STG_ONE;
                        rst_out_s = rst_out_r << 1'b1;
                        if ((stage_r + STG_ONE) == LAST_STAGE) begin
                            state_s = ST_RUN;
                            ready_s = 1'b1;
                        end else begin
                            state_s = ST_RELEASE;
                        end
                    end else begin
                        cnt_s = cnt_inc_s;
                    end
                end
                ST_RUN: begin
                    pll_pd_s = 1'b0;
                    ready_s  = 1'b1;
                end
                default: begin
                    state_s   = ST_PD;
                    cnt_s     = CNT_ZERO;
                    stage_s   = STG_ZERO;
                    pll_pd_s  = 1'b1;
                    rst_out_s = RST_ALL;
                    ready_s   = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_PD;
            cnt_r     <= CNT_ZERO;
            stage_r   <= STG_ZERO;
            pll_pd_r  <= 1'b1;
            rst_out_r <= RST_ALL;
            ready_r   <= 1'b0;
            lost_r    <= 8'd0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            stage_r   <= stage_s;
            pll_pd_r  <= pll_pd_s;
            rst_out_r <= rst_out_s;
            ready_r   <= ready_s;
            lost_r    <= lost_s;
        end
    end

`ifdef PLL_RST_SEQ_TIMEOUT_EN
    // Sticky timeout flag; only the hard reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_s;
        end
    end

    assign fault = fault_r;
`else
    assign fault = 1'b0;
`endif

    assign pll_pd        = pll_pd_r;
    assign rst_out       = rst_out_r;
    assign ready         = ready_r;
    assign lock_lost_cnt = lost_r;
    assign state         = state_r;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with PD=4, TIMEOUT=20, STABLE=8, GAP=2, 3 domains.
// Timeout expectations follow PLL_RST_SEQ_TIMEOUT_EN.
module tb_pll_rst_seq;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       sw_reset_req;
    logic       pll_pd;
    logic [2:0] rst_out;
    logic       ready;
    logic       fault;
    logic [7:0] lock_lost_cnt;
    logic [2:0] state;

    int checks;
    int errors;

`ifdef PLL_RST_SEQ_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    pll_rst_seq #(
        .PD_CYCLES     (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .N_DOMAINS     (3),
        .STAGE_GAP     (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_lock      (pll_lock),
        .sw_reset_req  (sw_reset_req),
        .pll_pd        (pll_pd),
        .rst_out       (rst_out),
        .ready         (ready),
        .fault         (fault),
        .lock_lost_cnt (lock_lost_cnt),
        .state         (state)
    );

    // 100 MHz bench clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Directed stimulus sequence
    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        pll_lock     = 1'b1;
        sw_reset_req = 1'b0;
        #12;
        chk("rst_pll_pd", 32'(pll_pd), 32'd1);
        chk("rst_rst_out", 32'(rst_out), 32'd7);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_lost", 32'(lock_lost_cnt), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        rst = 1'b0;

        // clean bring-up
        tick(3);
        chk("up_pd_e3", 32'(pll_pd), 32'd1);
        chk("up_state_e3", 32'(state), 32'd0);
        tick(1);
        chk("up_pd_e4", 32'(pll_pd), 32'd0);
        chk("up_state_e4", 32'(state), 32'd1);
        tick(1);
        chk("up_state_e5", 32'(state), 32'd2);
        tick(7);
        chk("up_state_e12", 32'(state), 32'd2);
        chk("up_rst_e12", 32'(rst_out), 32'd7);
        tick(1);
        chk("up_rst_e13", 32'(rst_out), 32'd6);
        chk("up_state_e13", 32'(state), 32'd3);
        chk("up_ready_e13", 32'(ready), 32'd0);
        tick(1);
        chk("up_rst_e14", 32'(rst_out), 32'd6);
        tick(1);
        chk("up_rst_e15", 32'(rst_out), 32'd4);
        tick(1);
        chk("up_ready_e16", 32'(ready), 32'd0);
        tick(1);
        chk("up_rst_e17", 32'(rst_out), 32'd0);
        chk("up_ready_e17", 32'(ready), 32'd1);
        chk("up_state_e17", 32'(state), 32'd4);

        // lock loss in RUN
        pll_lock = 1'b0;
        tick(2);
        chk("loss_rst_e2", 32'(rst_out), 32'd0);
        chk("loss_ready_e2", 32'(ready), 32'd1);
        tick(1);
        chk("loss_rst_e3", 32'(rst_out), 32'd7);
        chk("loss_ready_e3", 32'(ready), 32'd0);
        chk("loss_lost_e3", 32'(lock_lost_cnt), 32'd1);
        chk("loss_state_e3", 32'(state), 32'd1);
        chk("loss_pd_e3", 32'(pll_pd), 32'd0);
        pll_lock = 1'b1;
        tick(10);
        chk("relock_state", 32'(state), 32'd2);
        chk("relock_rst_a", 32'(rst_out), 32'd7);
        tick(1);
        chk("relock_rst_b", 32'(rst_out), 32'd6);
        tick(2);
        chk("relock_rst_c", 32'(rst_out), 32'd4);
        tick(2);
        chk("relock_rst_d", 32'(rst_out), 32'd0);
        chk("relock_ready", 32'(ready), 32'd1);

        // software re-sequence, then glitchy lock in STABLE
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        chk("sw_state", 32'(state), 32'd0);
        chk("sw_pd", 32'(pll_pd), 32'd1);
        chk("sw_rst", 32'(rst_out), 32'd7);
        chk("sw_ready", 32'(ready), 32'd0);
        tick(3);
        chk("sw_pd_s3", 32'(pll_pd), 32'd1);
        tick(1);
        chk("sw_pd_s4", 32'(pll_pd), 32'd0);
        tick(1);
        chk("sw_state_s5", 32'(state), 32'd2);
        tick(2);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(1);
        chk("glitch_state_s9", 32'(state), 32'd2);
        tick(1);
        chk("glitch_state_s10", 32'(state), 32'd1);
        tick(1);
        chk("glitch_state_s11", 32'(state), 32'd2);
        tick(7);
        chk("glitch_state_s18", 32'(state), 32'd2);
        chk("glitch_rst_s18", 32'(rst_out), 32'd7);
        tick(1);
        chk("glitch_state_s19", 32'(state), 32'd3);
        chk("glitch_rst_s19", 32'(rst_out), 32'd6);
        chk("glitch_lost", 32'(lock_lost_cnt), 32'd1);

        // software request coinciding with lock loss in RELEASE
        pll_lock = 1'b0;
        tick(2);
        chk("swl_state_pre", 32'(state), 32'd3);
        chk("swl_rst_pre", 32'(rst_out), 32'd4);
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        chk("swl_state", 32'(state), 32'd0);
        chk("swl_rst", 32'(rst_out), 32'd7);
        chk("swl_pd", 32'(pll_pd), 32'd1);
        chk("swl_lost", 32'(lock_lost_cnt), 32'd2);

        // lock timeout with pll_lock held low
        tick(3);
        chk("to_pd_t3", 32'(pll_pd), 32'd1);
        tick(1);
        chk("to_pd_t4", 32'(pll_pd), 32'd0);
        chk("to_state_t4", 32'(state), 32'd1);
        tick(19);
        chk("to_state_t23", 32'(state), 32'd1);
        chk("to_fault_t23", 32'(fault), 32'd0);
        tick(1);
        chk("to_pd_t24", 32'(pll_pd), 32'(TO_EN));
        chk("to_fault_t24", 32'(fault), 32'(TO_EN));
        chk("to_state_t24", 32'(state), TO_EN ? 32'd0 : 32'd1);
        tick(3);
        chk("to_pd_t27", 32'(pll_pd), 32'(TO_EN));
        tick(1);
        chk("to_pd_t28", 32'(pll_pd), 32'd0);
        chk("to_state_t28", 32'(state), 32'd1);
        tick(19);
        chk("to_pd_t47", 32'(pll_pd), 32'd0);
        tick(1);
        chk("to_pd_t48", 32'(pll_pd), 32'(TO_EN));
        chk("to_lost", 32'(lock_lost_cnt), 32'd2);

        // recover to RUN; fault must stay sticky across the software request
        pll_lock     = 1'b1;
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        chk("rec_state", 32'(state), 32'd0);
        tick(16);
        chk("rec_rst_u16", 32'(rst_out), 32'd4);
        chk("rec_state_u16", 32'(state), 32'd3);
        tick(1);
        chk("rec_ready", 32'(ready), 32'd1);
        chk("rec_fault", 32'(fault), 32'(TO_EN));

        // asynchronous reset mid-RUN, between clock edges
        #3;
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_pd", 32'(pll_pd), 32'd1);
        chk("arst_rst", 32'(rst_out), 32'd7);
        chk("arst_ready", 32'(ready), 32'd0);
        chk("arst_fault", 32'(fault), 32'd0);
        chk("arst_lost", 32'(lock_lost_cnt), 32'd0);
        #2;
        rst = 1'b0;
        tick(17);
        chk("arst_up_ready", 32'(ready), 32'd1);
        chk("arst_up_rst", 32'(rst_out), 32'd0);

        // repeated lock losses drive the counter into saturation
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            tick(3);
            pll_lock = 1'b1;
            tick(11);
            if (i == 0) begin
                chk("sat_lost_1", 32'(lock_lost_cnt), 32'd1);
            end
            if (i == 99) begin
                chk("sat_lost_100", 32'(lock_lost_cnt), 32'd100);
            end
            if (i == 254) begin
                chk("sat_lost_255", 32'(lock_lost_cnt), 32'd255);
            end
        end
        chk("sat_lost_final", 32'(lock_lost_cnt), 32'd255);
        chk("sat_state_final", 32'(state), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_rst_seq.md
# pll_rst_seq

PLL power-up and reset sequencer for the A3P1000 interface board. It sits between the fabric PLL and every downstream clock domain. It holds the PLL in power-down, waits for a stable lock, then releases the per-domain resets in a fixed staged order. On lock loss or a software request it re-asserts all domain resets and repeats the sequence.

## Interface
- PD_CYCLES, 16: cycles `pll_pd` is held high on each power-down.
- LOCK_TIMEOUT, 50000: WAIT_LOCK cycle limit (1 ms at 50 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized lock cycles required.
- N_DOMAINS, 3: number of staged domain resets.
- STAGE_GAP, 8: cycles between successive domain releases.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; **one clock; asynchronous, active-high**.
- pll_lock  in  1  PLL LOCK; asynchronous; synchronized internally.
- sw_reset_req  in  1  single-cycle pulse requesting a full re-sequence.
- pll_pd  out  1  PLL power-down, active-high.
- rst_out  out  N_DOMAINS  per-domain reset, active-high; bit 0 is released first.
- ready  out  1  all domains released, PLL locked.
- fault  out  1  sticky; set on lock timeout; cleared only by `rst`.
- lock_lost_cnt  out  8  count of lock losses seen in RELEASE/RUN; saturates at 255.
- state  out  3  current FSM state, for debug.

## Operation
- `pll_lock` passes through a 2-flop synchronizer (`lock_s`). This adds 2 cycles of latency.
- All outputs are registered.
- Reset values:
  - `pll_pd`=1
  - `rst_out`=all ones
  - `ready`=0
  - `fault`=0
  - `lock_lost_cnt`=0
  - `state`=PD
  - counters=0
- FSM states:
  - PD (0): `pll_pd`=1 for PD_CYCLES cycles, then go to WAIT_LOCK.
  - WAIT_LOCK (1): `pll_pd`=0 and the counter counts. If `lock_s`=1, go to STABLE with the counter cleared. If the counter reaches LOCK_TIMEOUT, set `fault` and go to PD.
  - STABLE (2): the counter increments while `lock_s`=1. If `lock_s`=0, go to WAIT_LOCK with the counter cleared. When the count reaches STABLE_CYCLES-1, go to RELEASE.
  - RELEASE (3): `rst_out[0]` clears in the first RELEASE cycle. `rst_out[i]` clears STAGE_GAP cycles after `rst_out[i-1]`. In the cycle the last bit clears, set `ready`=1 and go to RUN.
  - RUN (4): hold. No other state codes are legal; an illegal code goes to PD.
- Lock loss (`lock_s`=0) in RELEASE or RUN:
  - next cycle, `rst_out` goes to all ones and `ready`=0;
  - `lock_lost_cnt` increments, saturating;
  - go to WAIT_LOCK. The PLL is not powered down.
- `sw_reset_req` in any state:
  - next cycle, state=PD, `rst_out`=all ones, `ready`=0, PD counter restarts;
  - `sw_reset_req` has priority over every other transition;
  - if it coincides with a lock loss in RELEASE/RUN, `lock_lost_cnt` still increments.
- `sw_reset_req` during PD restarts the PD count.
- Counter width is `$clog2` of the largest of PD_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES, plus 1. The counter never wraps.

## Timing
- `rst` assertion forces reset values immediately, asynchronously, from any state.
- After `rst` deassertion, counting clk rising edges with `pll_lock` held high throughout, `ready` rises after PD_CYCLES + 1 + STABLE_CYCLES + (N_DOMAINS-1)*STAGE_GAP edges.
- From a `pll_lock` fall, `rst_out` reasserts at edge 3: 2 synchronizer cycles plus 1 register cycle.
- From `sw_reset_req`, `rst_out` reasserts and `pll_pd` rises at edge 1.

## Configuration
- Macro: `PLL_RST_SEQ_TIMEOUT_EN`.
- When defined, the WAIT_LOCK timeout is active as described above.
- When undefined:
  - the timeout logic is removed and WAIT_LOCK waits indefinitely;
  - `fault` is tied to 0.

## Structure
- Package `pll_seq_pkg` holds the state encodings (PD..RUN, 3 bits) and the counter-width function.
- Sub-module `sync2` is the 2-flop synchronizer. Its reset is asynchronous, active-high, and resets the flops to 0.
- Everything else (FSM, counter, stage index, `lock_lost_cnt`) lives in `pll_rst_seq`.

## Test plan
All scenarios use PD_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, STAGE_GAP=2, N_DOMAINS=3.

- **Clean bring-up:** `pll_lock`=1 throughout.
  - `pll_pd` is low from edge 4.
  - `rst_out` goes 3'b111 → 3'b110 (edge 13) → 3'b100 (15) → 3'b000 (17).
  - `ready`=1 at edge 17.
- **Glitchy lock:** `pll_lock` drops for 1 cycle mid-STABLE.
  - Returns to WAIT_LOCK and the full 8-cycle stability count restarts.
  - `lock_lost_cnt` stays 0.
- **Lock loss in RUN:** `pll_lock` falls.
  - `rst_out`=3'b111 and `ready`=0 three edges later.
  - `lock_lost_cnt`=1.
  - The staged release repeats once lock returns.
- **Timeout:** `pll_lock`=0.
  - With the macro defined: after 20 WAIT_LOCK cycles, `fault`=1 and `pll_pd` pulses for 4 cycles, repeating.
  - Without the macro: no `pll_pd` pulse and `fault`=0.
- **Software re-sequence:** `sw_reset_req` pulse during RELEASE coinciding with a lock fall.
  - State=PD next edge and `rst_out`=3'b111.
  - `lock_lost_cnt` increments by 1.
- **Async reset mid-RUN and saturation:**
  - `rst` mid-RUN gives reset values without a clock edge.
  - 300 lock losses give `lock_lost_cnt`=255.
